// File: rtl/rx_ber_checker.sv
// rx_ber_checker
// Receive-side BER checker for one I or Q branch of the QPSK link.
// The block decimates the pulse-shaped sample stream at a selectable phase
// and hard-slices each kept sample to a bit. A local PRBS9 reference
// (x^9 + x^5 + 1) synchronises itself to that bit stream, and the block then
// accumulates saturating bit and error counts while it holds lock.
//
// Pipeline:
//   edge t   : sample kept -> o_bit / o_bit_valid registered
//   edge t+1 : that bit is compared -> LFSR, window counters, global
//              counters and o_lock update
// The comparison stage is driven by the pending o_bit_valid pulse and not
// by enable. A bit that was already decided when enable fell is therefore
// still consumed, and the reference stays aligned across a stall.

module rx_ber_checker #(
  parameter int OS     = 4,
  parameter int DATA_W = 8,
  parameter int WIN    = 64,
  parameter int ERR_TH = 8,
  parameter int CNT_W  = 32,
  parameter int PH_W   = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] i_rx,
  input  logic [PH_W-1:0]   i_phase,
  input  logic              i_clear,
  output logic              o_bit,
  output logic              o_bit_valid,
  output logic              o_lock,
  output logic [CNT_W-1:0]  o_err_count,
  output logic [CNT_W-1:0]  o_bit_count
);

  // Counter widths. The window bit counter only has to reach WIN-1. The
  // window error counter must hold the full WIN when every bit is wrong.
  localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int WE_W = $clog2(WIN + 1);
  localparam int SC_W = 4;

  typedef enum logic [1:0] {
    SYNC,
    ACQ,
    LOCKED
  } state_t;

  // Decimation and slicer registers
  logic [PH_W-1:0]  pc_q;
  logic             bit_q;
  logic             valid_q;

  // Synchroniser / monitor registers
  state_t           state_q;
  logic [8:0]       s_q;
  logic [SC_W-1:0]  syncCnt_q;
  logic [WC_W-1:0]  winCnt_q;
  logic [WE_W-1:0]  winErr_q;
  logic             lock_q;

  // Global measurement counters
  logic [CNT_W-1:0] errCnt_q;
  logic [CNT_W-1:0] bitCnt_q;

  // Combinational helpers
  logic             keep;
  logic [PH_W-1:0]  pc_d;
  logic             pred;
  logic             err;
  logic [WE_W-1:0]  winErrNext;
  logic             winLast;
  logic             cntEn;

  // Only the sign bit matters for a hard decision. The remaining sample
  // bits are folded here so that they are visibly consumed.
  logic             unusedRxBits;
  assign unusedRxBits = ^i_rx[DATA_W-2:0];

  assign keep = enable && (pc_q == i_phase);
  assign pc_d = (pc_q == PH_W'(OS - 1)) ? '0 : pc_q + PH_W'(1);

  // Reference prediction from the x^9 + x^5 taps. s_q[0] is the newest bit.
  assign pred       = s_q[8] ^ s_q[4];
  assign err        = bit_q ^ pred;
  assign winErrNext = winErr_q + WE_W'(err);
  assign winLast    = (winCnt_q == WC_W'(WIN - 1));

  // Global counters move only for bits compared while LOCKED. This
  // includes the bit that closes a failing window, because the state is
  // still LOCKED at the moment that bit is compared.
  assign cntEn = valid_q && (state_q == LOCKED);

  // Phase counter, decimator and slicer. The valid pulse is rewritten
  // every cycle, so it lasts exactly one cycle whether enable is high or not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= keep;
      if (enable) begin
        pc_q <= pc_d;
      end
      if (keep) begin
        bit_q <= ~i_rx[DATA_W-1];
      end
    end
  end

  // Synchronisation FSM with reference LFSR, window monitor and lock flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SYNC;
      s_q       <= '0;
      syncCnt_q <= '0;
      winCnt_q  <= '0;
      winErr_q  <= '0;
      lock_q    <= 1'b0;
    end else if (valid_q) begin
      case (state_q)
        SYNC: begin
          s_q <= {s_q[7:0], bit_q};
          if (syncCnt_q == SC_W'(8)) begin
            syncCnt_q <= '0;
            winCnt_q  <= '0;
            winErr_q  <= '0;
            state_q   <= ACQ;
          end else begin
            syncCnt_q <= syncCnt_q + SC_W'(1);
          end
        end
        ACQ, LOCKED: begin
          s_q <= {s_q[7:0], pred};
          if (winLast) begin
            winCnt_q <= '0;
            winErr_q <= '0;
            if (winErrNext < WE_W'(ERR_TH)) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
            end else begin
              state_q   <= SYNC;
              syncCnt_q <= '0;
              lock_q    <= 1'b0;
            end
          end else begin
            winCnt_q <= winCnt_q + WC_W'(1);
            winErr_q <= winErrNext;
          end
        end
        default: begin
          state_q <= SYNC;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating bit and error counters. A clear wins over an increment on
  // the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      errCnt_q <= '0;
      bitCnt_q <= '0;
    end else if (i_clear) begin
      errCnt_q <= '0;
      bitCnt_q <= '0;
    end else if (cntEn) begin
      if (bitCnt_q != '1) begin
        bitCnt_q <= bitCnt_q + CNT_W'(1);
      end
      if (err && (errCnt_q != '1)) begin
        errCnt_q <= errCnt_q + CNT_W'(1);
      end
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = valid_q;
  assign o_lock      = lock_q;
  assign o_err_count = errCnt_q;
  assign o_bit_count = bitCnt_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// tb_rx_ber_checker
// Scoreboard bench for rx_ber_checker. Each transmitted symbol is driven as
// four samples. The kept phase carries the sliced bit, and the other phases
// carry random values. For every symbol the stimulus pushes the expected
// bit, lock flag and counter values, taken from a sequence-level model of
// the PRBS9 self-synchroniser. A monitor pops an entry whenever the DUT
// pulses o_bit_valid and compares the results one cycle later.

module tb_rx_ber_checker;

  localparam int OS     = 4;
  localparam int DATA_W = 8;
  localparam int WIN    = 64;
  localparam int ERR_TH = 8;
  localparam int CNT_W  = 32;
  localparam logic [1:0] PHASE = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [DATA_W-1:0] i_rx;
  logic [1:0]        i_phase;
  logic              i_clear;
  logic              o_bit;
  logic              o_bit_valid;
  logic              o_lock;
  logic [CNT_W-1:0]  o_err_count;
  logic [CNT_W-1:0]  o_bit_count;

  always #5 clk = ~clk;

  rx_ber_checker #(
    .OS(OS), .DATA_W(DATA_W), .WIN(WIN), .ERR_TH(ERR_TH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .i_rx(i_rx),
    .i_phase(i_phase),
    .i_clear(i_clear),
    .o_bit(o_bit),
    .o_bit_valid(o_bit_valid),
    .o_lock(o_lock),
    .o_err_count(o_err_count),
    .o_bit_count(o_bit_count)
  );

  typedef struct {
    bit     b;
    bit     lock;
    longint errs;
    longint bits;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  // Reference model state: phase 0 = gathering seed bits, 1 = acquiring,
  // 2 = locked. refHist holds the last nine reference bits, oldest first.
  int     mMode;
  int     mPos;
  int     mWinErr;
  longint mErr;
  longint mBits;
  bit     refHist[$];

  // Transmit PRBS9 source: the last nine sent bits, oldest first
  bit     txHist[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checkCount++;
    if (act === expv) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic bit nextTx();
    bit nb;
    nb = txHist[0] ^ txHist[4];
    txHist.push_back(nb);
    void'(txHist.pop_front());
    return nb;
  endfunction

  task automatic modelReset();
    mMode   = 0;
    mPos    = 0;
    mWinErr = 0;
    mErr    = 0;
    mBits   = 0;
    refHist.delete();
  endtask

  // Sequence-level model: the prediction for a bit is the XOR of the
  // reference bits nine and five positions back.
  task automatic modelBit(input bit b, input bit clr, output exp_t e);
    bit pred;
    bit er;
    if (mMode == 0) begin
      refHist.push_back(b);
      if (refHist.size() > 9) void'(refHist.pop_front());
      mPos++;
      if (mPos == 9) begin
        mMode   = 1;
        mPos    = 0;
        mWinErr = 0;
      end
    end else begin
      pred = refHist[0] ^ refHist[4];
      er   = b ^ pred;
      refHist.push_back(pred);
      void'(refHist.pop_front());
      if (mMode == 2) begin
        mBits++;
        mErr += longint'(er);
      end
      mWinErr += int'(er);
      mPos++;
      if (mPos == WIN) begin
        mMode   = (mWinErr < ERR_TH) ? 2 : 0;
        mPos    = 0;
        mWinErr = 0;
        if (mMode == 0) refHist.delete();
      end
    end
    if (clr) begin
      mErr  = 0;
      mBits = 0;
    end
    e.b    = b;
    e.lock = (mMode == 2);
    e.errs = mErr;
    e.bits = mBits;
  endtask

  task automatic driveCycle(input bit en, input logic [DATA_W-1:0] rx, input bit clr);
    enable  = en;
    i_rx    = rx;
    i_clear = clr;
    @(posedge clk);
    #1;
  endtask

  // Kept sample for a bit. Zero and -1 occur often so the slicer boundary
  // is exercised.
  function automatic logic [DATA_W-1:0] keptSample(input bit b);
    int r;
    r = $urandom_range(0, 7);
    if (b) return (r == 0) ? 8'h00 : 8'($urandom_range(0, 127));
    else   return (r == 0) ? 8'hFF : 8'(256 - $urandom_range(1, 128));
  endfunction

  // One symbol of four samples, with an optional stall right after the kept
  // sample. The clear strobe lands on the edge that compares this bit.
  task automatic applyStimulus(input bit txBit, input bit inject, input bit clr, input int stall);
    exp_t e;
    bit   rb;
    rb = txBit ^ inject;
    modelBit(rb, clr, e);
    expQ.push_back(e);
    driveCycle(1'b1, 8'($urandom), 1'b0);
    driveCycle(1'b1, 8'($urandom), 1'b0);
    driveCycle(1'b1, keptSample(rb), 1'b0);
    for (int k = 0; k < stall; k++) driveCycle(1'b0, 8'($urandom), 1'b0);
    driveCycle(1'b1, 8'($urandom), clr);
  endtask

  task automatic sendClean(input int n);
    for (int k = 0; k < n; k++) applyStimulus(nextTx(), 1'b0, 1'b0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bit"},   o_bit, 0);
    checkOutput({tag, "_valid"}, o_bit_valid, 0);
    checkOutput({tag, "_lock"},  o_lock, 0);
    checkOutput({tag, "_err"},   o_err_count, 0);
    checkOutput({tag, "_bits"},  o_bit_count, 0);
  endtask

  // Monitor: every valid pulse consumes one scoreboard entry
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && o_bit_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedValid: got o_bit_valid=1, expected 0");
        end else begin
          me = expQ.pop_front();
          checkOutput("bit", o_bit, me.b);
          @(negedge clk);
          checkOutput("validPulse", o_bit_valid, 0);
          checkOutput("lock", o_lock, me.lock);
          checkOutput("errCount", o_err_count, me.errs);
          checkOutput("bitCount", o_bit_count, me.bits);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint savedErr;
    longint savedBits;
    int     rate;

    rst     = 1'b0;
    enable  = 1'b0;
    i_clear = 1'b0;
    i_rx    = '0;
    i_phase = PHASE;
    for (int k = 0; k < 9; k++) txHist.push_back(1'b0);
    begin
      logic [8:0] seed;
      seed = 9'($urandom_range(1, 511));
      for (int k = 0; k < 9; k++) txHist[k] = seed[k];
    end
    modelReset();

    // Reset with enable high and the kept phase active
    for (int k = 0; k < 4; k++) driveCycle(1'b1, 8'($urandom), 1'b0);
    checkResetOutputs("reset");
    rst = 1'b1;

    // Ideal lock after 9 + WIN bits
    $display("[TB] ideal lock");
    sendClean(72);
    checkOutput("noLockAt72", o_lock, 0);
    sendClean(1);
    checkOutput("lockAt73", o_lock, 1);
    sendClean(1000);
    checkOutput("ideal_bits1000", o_bit_count, 1000);
    checkOutput("ideal_err0", o_err_count, 0);

    // Sparse errors: one in 32 for 640 bits
    $display("[TB] sparse errors");
    for (int k = 0; k < 640; k++) applyStimulus(nextTx(), (k % 32) == 31, 1'b0, 0);
    checkOutput("sparse_lock", o_lock, 1);
    checkOutput("sparse_err20", o_err_count, 20);
    checkOutput("sparse_bits", o_bit_count, 1640);

    // Clear coincident with an error bit
    $display("[TB] clear");
    sendClean(5);
    applyStimulus(nextTx(), 1'b1, 1'b1, 0);
    checkOutput("clear_err", o_err_count, 0);
    checkOutput("clear_bits", o_bit_count, 0);
    checkOutput("clear_lock", o_lock, 1);
    sendClean(10);
    checkOutput("clear_resume", o_bit_count, 10);

    // Enable stall of 37 cycles mid-symbol
    $display("[TB] enable stall");
    savedBits = longint'(o_bit_count);
    applyStimulus(nextTx(), 1'b0, 1'b0, 37);
    checkOutput("stall_bits", o_bit_count, savedBits + 1);
    sendClean(100);
    checkOutput("stall_err", o_err_count, 0);
    checkOutput("stall_lock", o_lock, 1);

    // Burst of 10 errors kept inside one window
    $display("[TB] burst errors");
    while (mPos != 10) sendClean(1);
    for (int k = 0; k < 10; k++) applyStimulus(nextTx(), 1'b1, 1'b0, 0);
    while (mPos != 0) sendClean(1);
    checkOutput("burst_unlock", o_lock, 0);
    savedErr  = longint'(o_err_count);
    savedBits = longint'(o_bit_count);
    sendClean(72);
    checkOutput("burst_stillUnlocked", o_lock, 0);
    checkOutput("burst_frozenErr", o_err_count, savedErr);
    checkOutput("burst_frozenBits", o_bit_count, savedBits);
    sendClean(1);
    checkOutput("burst_relock", o_lock, 1);
    sendClean(20);

    // Reset for one cycle while locked
    $display("[TB] reset mid-operation");
    rst = 1'b0;
    driveCycle(1'b1, 8'($urandom), 1'b0);
    checkResetOutputs("midReset");
    rst = 1'b1;
    modelReset();
    sendClean(72);
    checkOutput("midReset_noLock", o_lock, 0);
    sendClean(1);
    checkOutput("midReset_relock", o_lock, 1);

    // Random error rates per window, crossing the threshold both ways
    $display("[TB] random error rates");
    rate = 0;
    for (int k = 0; k < 1200; k++) begin
      if ((k % WIN) == 0) rate = $urandom_range(0, 25);
      applyStimulus(nextTx(), $urandom_range(0, 99) < rate, 1'b0, 0);
    end

    for (int k = 0; k < 4; k++) driveCycle(1'b0, 8'($urandom), 1'b0);
    checkOutput("queueDrained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rx_ber_checker.md
# rx_ber_checker

Receive-side stage directly downstream of the QPSK transmit pulse-shaping filter (one I or Q branch). It consumes the signed 8-bit filtered samples at four samples per symbol and decimates them at a selectable phase. It slices each kept sample to a hard bit, self-synchronises a local PRBS9 reference to the bit stream, and accumulates bit and error counts for BER measurement.

## Interface
Parameters:
- `OS`, 4: samples per symbol; phase counter width is clog2(OS).
- `DATA_W`, 8: signed sample width.
- `WIN`, 64: bits per error-monitoring window.
- `ERR_TH`, 8: errors within one window that force resync.
- `CNT_W`, 32: width of the bit and error counters.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-low. Sampled on the `clk` rising edge.
- `enable`, in, 1: sample strobe. When low, all state holds.
- `i_rx`, in, DATA_W: signed filter output sample.
- `i_phase`, in, 2: decimation phase, 0..OS-1.
- `i_clear`, in, 1: synchronous clear of the counters.
- `o_bit`, out, 1: sliced decision bit.
- `o_bit_valid`, out, 1: one-cycle pulse marking a new `o_bit`.
- `o_lock`, out, 1: high while in LOCKED.
- `o_err_count`, out, CNT_W: errors counted in LOCKED. Saturating.
- `o_bit_count`, out, CNT_W: bits compared in LOCKED. Saturating.

## Operation
- **Phase counter `pc`:**
  - Counts 0..OS-1, wraps, and advances only on `enable`=1.
  - A sample is kept when `enable`=1 and `pc`==`i_phase`.
- **Slicer:** `o_bit` = ~`i_rx`[DATA_W-1]. A value ≥0 gives 1; a negative value gives 0. This matches the transmit mapping, where 1 is sent as +pulse.
- **Reference LFSR `s[8:0]`:**
  - Polynomial x^9+x^5+1.
  - `pred` = s[8]^s[4].
  - On each valid bit, s <= {s[7:0], x}.
  - x is the received bit in SYNC and `pred` in ACQ or LOCKED.
  - `err` = `o_bit`^`pred`. It is evaluated only in ACQ and LOCKED.
- **States:**
  - SYNC: shifts 9 received bits into `s`. After the 9th bit, go to ACQ. The window counter and window error counter are zero.
  - ACQ: compares WIN bits. At the end of the window, if window errors < ERR_TH go to LOCKED, otherwise go to SYNC.
  - LOCKED: compares continuously. Every WIN bits the window is evaluated; window errors ≥ ERR_TH go to SYNC, otherwise stay in LOCKED. The window counters restart each window.
- **Global counters:**
  - Count only bits compared in LOCKED, including the bit that closes a failing window.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
- **`i_clear`:**
  - Zeroes both global counters on the next edge.
  - Has priority over a simultaneous increment.
  - Does not affect the state, the LFSR or the window counters.
- **`i_phase` change:** takes effect on the next comparison against `pc`. No resync is forced; lock loss, if any, comes through the window mechanism.
- **Reset (rst=0), including mid-operation:**
  - `pc`, `s`, `o_bit`, `o_bit_valid`, `o_lock`, `o_err_count`, `o_bit_count` and the window counters are all 0.
  - State returns to SYNC.

## Timing
- Sample kept at edge t, so `o_bit` and `o_bit_valid`=1 are registered at t+1.
- Decision latency is 1 clk.
- The comparison of that bit updates the LFSR, window counters and global counters at t+2.
- A state change caused by that bit is visible on `o_lock` at t+2.
- `o_bit_valid` pulses once per OS enabled cycles. With `enable` stuck at 1 that is a 1-in-4 duty cycle.
- **Minimum time to lock:** 9 + WIN = 73 valid bits after leaving reset, i.e. 292 enabled clks plus pipeline delay.
- **Lock loss:** `o_lock` falls at t+2 of the bit that closes a failing window. SYNC restarts with the next valid bit.
- **`enable`=0:** every register holds. A pending `o_bit_valid` pulse lasts exactly one enabled-or-not cycle and is then cleared.

## Test plan
- **Ideal lock.** Stimulus: noiseless transmit-filter output driven by a PRBS9 source, `i_phase` at eye centre, `enable`=1. Response: `o_lock` rises after 73 valid bits. After a further 1000 bits, `o_bit_count`=1000 and `o_err_count`=0.
- **Sparse errors.** Stimulus: locked, then 1 in every 32 received bits inverted for 640 bits. Response: `o_lock` stays 1 and `o_err_count`=20.
- **Burst errors.** Stimulus: 10 consecutive inverted bits inside one window. Response: `o_lock` falls at that window's end, then relocks 73 bits later. Counters freeze while unlocked.
- **Clear.** Stimulus: `i_clear` pulsed while locked, coincident with an error bit. Response: both counters are 0 on the next cycle and then resume from 0. `o_lock` is unaffected.
- **Enable stall.** Stimulus: `enable` held low for 37 cycles mid-stream. Response: no `o_bit_valid` pulses, and counters and state are unchanged. The stream resumes error-free.
- **Reset mid-operation.** Stimulus: `rst`=0 for 1 cycle while locked. Response: all outputs read 0 the next cycle, state is SYNC, and relock occurs after 73 bits.
